instr_issue_queue: RTL

- Consumer end of the instruction fetch stream: accepts {pc, instruction} words from the fetch stage and buffers them in a small FIFO.
- Detects the halt word and splits each instruction into VLIW slot fields.
- Issues to the datapath under a valid/ready handshake.
- Sits between instruction fetch and the SIMD execute/control logic.

---
 rtl/issue_pkg.sv | 18 +
 rtl/instr_issue_queue_sync_fifo.sv | 56 +++++
 rtl/instr_issue_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue queue: halt word,
// VLIW slot field positions and the issue FSM state encoding.
package issue_pkg;

   localparam logic [15:0] HALT_WORD = 16'hFFFF;

   localparam int OPC_MSB  = 15;
   localparam int DST_MSB  = 11;
   localparam int SRCA_MSB = 7;
   localparam int SRCB_MSB = 3;
   localparam int FIELD_W  = 4;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

endpackage

// File: rtl/instr_issue_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush and a combinational
// head output. DEPTH must be a power of two so pointers wrap naturally.
// Flush has priority over push and pop in the same cycle.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush simply rewinds to empty.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: buffers {pc, instr} words from fetch, stops at the
// halt word and issues decoded VLIW slot fields under valid/ready.
// Optional build macro ISSUE_PERF_CNT_EN adds issued/stall counters.
module instr_issue_queue #(
   parameter int          DEPTH     = 4,
   parameter int          PC_W      = 16,
   parameter int          INSTR_W   = 16,
   parameter logic [15:0] HALT_WORD = issue_pkg::HALT_WORD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [3:0]         out_opcode,
   output logic [3:0]         out_dst,
   output logic [3:0]         out_src_a,
   output logic [3:0]         out_src_b,
   output logic               halted
`ifdef ISSUE_PERF_CNT_EN
   ,
   output logic [15:0]        issued_cnt,
   output logic [15:0]        stall_cnt
`endif
);

   import issue_pkg::*;

   localparam int EW = PC_W + INSTR_W;

   state_t             state_q;
   state_t             state_d;
   logic               fifo_full;
   logic               fifo_empty;
   logic [EW-1:0]      fifo_head;
   logic [PC_W-1:0]    head_pc;
   logic [INSTR_W-1:0] head_instr;
   logic               push;
   logic               pop_fire;
   logic               halt_take;

   assign head_pc    = fifo_head[EW-1 -: PC_W];
   assign head_instr = fifo_head[INSTR_W-1:0];

   // The halt word at the head is swallowed without a handshake; an
   // explicit flush in the same cycle wins and leaves the state alone.
   assign halt_take = (state_q == ST_RUN) && !fifo_empty &&
                      (head_instr == HALT_WORD) && !flush;

   assign in_ready  = !fifo_full && (state_q == ST_RUN) && !flush;
   assign out_valid = !fifo_empty && (state_q == ST_RUN) &&
                      (head_instr != HALT_WORD);
   assign push      = in_valid && in_ready;
   assign pop_fire  = out_valid && out_ready && !flush;

   assign out_pc     = head_pc;
   assign out_opcode = head_instr[OPC_MSB  -: FIELD_W];
   assign out_dst    = head_instr[DST_MSB  -: FIELD_W];
   assign out_src_a  = head_instr[SRCA_MSB -: FIELD_W];
   assign out_src_b  = head_instr[SRCB_MSB -: FIELD_W];
   assign halted     = (state_q == ST_HALTED);

   sync_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop_fire || halt_take),
      .flush (flush || halt_take),
      .din   ({in_pc, in_instr}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Issue state register; only reset leaves HALTED.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   // Next-state logic: RUN moves to HALTED when the halt word is consumed.
   always_comb begin
      state_d = state_q;
      if ((state_q == ST_RUN) && halt_take) state_d = ST_HALTED;
   end

`ifdef ISSUE_PERF_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating issue/stall counters, frozen once the program has halted.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else if (state_q == ST_RUN) begin
         if (pop_fire)               issued_cnt <= sat_inc(issued_cnt);
         if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
      end
   end
`endif

endmodule
